jb_report_decoder: RTL and testbench

Downstream consumer of the JOYBUS host's receive path. It takes each 32-bit N64 controller response, latches the 16 button bits and both stick axes, and applies a stick deadzone. It emits per-button press/release pulses and tracks controller presence from missed or errored polls. Game/UI logic reads its registered outputs instead of the raw host buttons.

---
 rtl/jb_pkg.sv | 32 +++
 rtl/jb_deadzone.sv | 18 +
 rtl/jb_report_decoder.sv | 124 ++++++++++++
 tb/tb_jb_report_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jb_pkg.sv
// Shared types for the JOYBUS report decoder: button indices, response layout, FSM state.
package jb_pkg;

  localparam int BTN_A     = 15;
  localparam int BTN_B     = 14;
  localparam int BTN_Z     = 13;
  localparam int BTN_START = 12;
  localparam int BTN_DU    = 11;
  localparam int BTN_DD    = 10;
  localparam int BTN_DL    = 9;
  localparam int BTN_DR    = 8;
  localparam int BTN_RST   = 7;
  localparam int BTN_RSVD  = 6;
  localparam int BTN_L     = 5;
  localparam int BTN_R     = 4;
  localparam int BTN_CU    = 3;
  localparam int BTN_CD    = 2;
  localparam int BTN_CL    = 1;
  localparam int BTN_CR    = 0;

  typedef struct packed {
    logic [15:0] btn;
    logic [7:0]  x;
    logic [7:0]  y;
  } jb_resp_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } jb_dec_state_t;

endpackage

// File: rtl/jb_deadzone.sv
// One stick axis: clamp -128 to -127, then zero anything within +/-DEADZONE.
// Purely combinational.
module jb_deadzone #(
  parameter int unsigned DEADZONE = 8
) (
  input  logic [7:0] i_raw,
  output logic [7:0] o_axis
);

  logic [7:0] w_clamp;
  logic [7:0] w_mag;

  // Clamping first keeps the magnitude representable in 7 bits.
  assign w_clamp = (i_raw == 8'h80) ? 8'h81 : i_raw;
  assign w_mag   = w_clamp[7] ? (~w_clamp + 8'd1) : w_clamp;
  assign o_axis  = (32'(w_mag) <= DEADZONE) ? 8'h00 : w_clamp;

endmodule

// File: rtl/jb_report_decoder.sv
// Latches N64 controller responses into registered buttons/axes, edge pulses and presence.
// Outputs update one cycle after rx_valid / rx_err / final timeout cycle.
module jb_report_decoder
  import jb_pkg::*;
#(
  parameter int unsigned DEADZONE    = 8,
  parameter int unsigned MISS_LIMIT  = 3,
  parameter int unsigned TIMEOUT_CYC = 25000,
  localparam int MW = $clog2(MISS_LIMIT + 1),
  localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_poll_start,
  input  logic          i_rx_valid,
  input  logic          i_rx_err,
  input  logic [31:0]   i_rx_data,
  output logic [15:0]   o_btn,
  output logic [15:0]   o_btn_pressed,
  output logic [15:0]   o_btn_released,
  output logic [7:0]    o_stick_x,
  output logic [7:0]    o_stick_y,
  output logic          o_report_valid,
  output logic          o_connected,
  output logic [MW-1:0] o_miss_cnt
);

  jb_dec_state_t r_state;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_btn;
  logic [15:0]   r_pressed;
  logic [15:0]   r_released;
  logic [7:0]    r_x;
  logic [7:0]    r_y;
  logic          r_rv;
  logic          r_conn;
  logic [MW-1:0] r_miss;

  jb_resp_t      w_resp;
  logic [7:0]    w_x;
  logic [7:0]    w_y;
  logic          w_wait;
  logic          w_tmo_hit;
  logic          w_good;
  logic          w_fail;
  logic [MW-1:0] w_miss_nxt;
  logic          w_drop;

  assign w_resp = i_rx_data;

  jb_deadzone #(.DEADZONE(DEADZONE)) u_dz_x (.i_raw(w_resp.x), .o_axis(w_x));
  jb_deadzone #(.DEADZONE(DEADZONE)) u_dz_y (.i_raw(w_resp.y), .o_axis(w_y));

  // rx_err dominates rx_valid; a re-issued poll or timeout only fails if no response arrived.
  assign w_wait     = (r_state == ST_WAIT);
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYC - 1));
  assign w_good     = w_wait & i_rx_valid & ~i_rx_err;
  assign w_fail     = w_wait & (i_rx_err | (~i_rx_valid & (i_poll_start | w_tmo_hit)));
  assign w_miss_nxt = (r_miss == MW'(MISS_LIMIT)) ? r_miss : r_miss + MW'(1);
  assign w_drop     = w_fail & r_conn & (w_miss_nxt == MW'(MISS_LIMIT));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
    end else if (i_poll_start) begin
      r_state <= ST_WAIT;
      r_tmo   <= '0;
    end else if (w_wait) begin
      if (w_good || w_fail) begin
        r_state <= ST_IDLE;
        r_tmo   <= '0;
      end else begin
        r_tmo   <= r_tmo + TW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn      <= '0;
      r_pressed  <= '0;
      r_released <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_rv       <= 1'b0;
      r_conn     <= 1'b0;
      r_miss     <= '0;
    end else begin
      r_pressed  <= '0;
      r_released <= '0;
      r_rv       <= 1'b0;
      if (w_good) begin
        r_btn      <= w_resp.btn;
        r_pressed  <= w_resp.btn & ~r_btn;
        r_released <= ~w_resp.btn & r_btn;
        r_x        <= w_x;
        r_y        <= w_y;
        r_rv       <= 1'b1;
        r_conn     <= 1'b1;
        r_miss     <= '0;
      end else if (w_fail) begin
        r_miss <= w_miss_nxt;
        if (w_drop) begin
          r_conn     <= 1'b0;
          r_btn      <= '0;
          r_released <= r_btn;
          r_x        <= '0;
          r_y        <= '0;
        end
      end
    end
  end

  assign o_btn          = r_btn;
  assign o_btn_pressed  = r_pressed;
  assign o_btn_released = r_released;
  assign o_stick_x      = r_x;
  assign o_stick_y      = r_y;
  assign o_report_valid = r_rv;
  assign o_connected    = r_conn;
  assign o_miss_cnt     = r_miss;

endmodule

// File: tb/tb_jb_report_decoder.sv
// Scoreboard bench for jb_report_decoder: reference model queues expected reports, monitor checks them.
module tb_jb_report_decoder;

  localparam int DZ  = 8;
  localparam int LIM = 3;
  localparam int TO  = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_start = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_err = 1'b0;
  logic [31:0] rx_data = '0;
  logic [15:0] btn, btn_pressed, btn_released;
  logic [7:0]  stick_x, stick_y;
  logic        report_valid, connected;
  logic [1:0]  miss_cnt;

  jb_report_decoder #(.DEADZONE(DZ), .MISS_LIMIT(LIM), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_poll_start(poll_start), .i_rx_valid(rx_valid),
    .i_rx_err(rx_err), .i_rx_data(rx_data), .o_btn(btn), .o_btn_pressed(btn_pressed),
    .o_btn_released(btn_released), .o_stick_x(stick_x), .o_stick_y(stick_y),
    .o_report_valid(report_valid), .o_connected(connected), .o_miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] btn, pr, rl;
    logic [7:0]  x, y;
    logic        rv, conn;
    logic [1:0]  miss;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  bit mon_en = 0;

  logic [15:0] m_btn = '0;
  logic [7:0]  m_x = '0, m_y = '0;
  logic        m_conn = 1'b0;
  int          m_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dz(input logic [7:0] r);
    int v;
    int mag;
    v = int'($signed(r));
    if (v == -128) v = -127;
    mag = (v < 0) ? -v : v;
    if (mag <= DZ) return 8'h00;
    return 8'(v);
  endfunction

  task automatic push_state(input logic [15:0] pr, input logic [15:0] rl, input logic rv);
    exp_t e;
    e.btn = m_btn; e.pr = pr; e.rl = rl; e.x = m_x; e.y = m_y;
    e.rv = rv; e.conn = m_conn; e.miss = 2'(m_miss);
    q.push_back(e);
  endtask

  task automatic model_good(input logic [31:0] d);
    logic [15:0] nb;
    logic [15:0] pr, rl;
    nb = d[31:16];
    pr = nb & ~m_btn;
    rl = ~nb & m_btn;
    m_btn = nb; m_x = dz(d[15:8]); m_y = dz(d[7:0]);
    m_miss = 0; m_conn = 1'b1;
    push_state(pr, rl, 1'b1);
  endtask

  task automatic model_fail();
    logic [15:0] rl;
    if (m_miss < LIM) begin
      rl = '0;
      m_miss++;
      if (m_conn && m_miss == LIM) begin
        rl = m_btn;
        m_conn = 1'b0; m_btn = '0; m_x = '0; m_y = '0;
      end
      push_state('0, rl, 1'b0);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic poll();
    poll_start = 1'b1; cyc(); poll_start = 1'b0;
  endtask

  task automatic rx(input logic v, input logic e, input logic [31:0] d);
    rx_valid = v; rx_err = e; rx_data = d; cyc();
    rx_valid = 1'b0; rx_err = 1'b0; rx_data = $urandom;
  endtask

  function automatic logic [7:0] rand_axis();
    logic [7:0] tbl [10];
    tbl = '{8'h80, 8'h81, 8'hF7, 8'hF8, 8'hFF, 8'h00, 8'h08, 8'h09, 8'h7F, 8'h00};
    if ($urandom_range(0, 2) == 0) return 8'($urandom);
    return tbl[$urandom_range(0, 9)];
  endfunction

  function automatic logic [31:0] rand_data();
    return {16'($urandom), rand_axis(), rand_axis()};
  endfunction

  // Monitor: any report pulse, miss count change or presence change consumes one expected entry.
  initial begin : monitor
    logic [1:0] prev_miss;
    logic       prev_conn;
    exp_t e;
    prev_miss = '0;
    prev_conn = 1'b0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (report_valid || miss_cnt != prev_miss || connected != prev_conn) begin
        if (q.size() == 0) begin
          chk("unexpected_event_rv", 32'(report_valid), 32'd0);
          chk("unexpected_event_miss", 32'(miss_cnt), 32'(prev_miss));
        end else begin
          e = q.pop_front();
          chk("btn", 32'(btn), 32'(e.btn));
          chk("pressed", 32'(btn_pressed), 32'(e.pr));
          chk("released", 32'(btn_released), 32'(e.rl));
          chk("stick_x", 32'(stick_x), 32'(e.x));
          chk("stick_y", 32'(stick_y), 32'(e.y));
          chk("report_valid", 32'(report_valid), 32'(e.rv));
          chk("connected", 32'(connected), 32'(e.conn));
          chk("miss_cnt", 32'(miss_cnt), 32'(e.miss));
        end
      end else begin
        chk("quiet_pulses", {btn_pressed, btn_released}, 32'd0);
      end
      prev_miss = miss_cnt;
      prev_conn = connected;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_btn", 32'(btn), 32'd0);
    chk("rst_pulses", {btn_pressed, btn_released}, 32'd0);
    chk("rst_sticks", {16'd0, stick_x, stick_y}, 32'd0);
    chk("rst_flags", {29'd0, report_valid, connected, 1'b0} | 32'(miss_cnt), 32'd0);
    rst = 1'b0;
    cyc();
    mon_en = 1;

    poll(); cyc();
    model_good(32'hA000_147F); rx(1, 0, 32'hA000_147F);
    cyc();
    poll(); cyc(); cyc();
    model_good(32'h2000_0580); rx(1, 0, 32'h2000_0580);
    cyc();
    for (int i = 0; i < 3; i++) begin
      model_fail(); poll();
      repeat (TO + 3) cyc();
    end
    poll(); model_good(32'h1234_2020); rx(1, 0, 32'h1234_2020);
    poll(); cyc();
    model_fail(); rx(1, 1, 32'hFFFF_7F7F);
    cyc();
    rx(1, 0, 32'h0000_0000);
    rx(0, 1, 32'h0);
    repeat (3) cyc();
    poll(); repeat (2) cyc();
    model_fail(); poll();
    repeat (10) cyc();
    model_good(32'h8001_F909); rx(1, 0, 32'h8001_F909);
    repeat (2) cyc();

    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      d = rand_data();
      case (k)
        0, 1, 2, 3: begin
          poll(); repeat ($urandom_range(0, TO - 6)) cyc();
          model_good(d); rx(1, 0, d);
        end
        4: begin
          poll(); repeat ($urandom_range(0, 10)) cyc();
          model_fail(); rx(0, 1, d);
        end
        5: begin
          poll(); repeat ($urandom_range(0, 10)) cyc();
          model_fail(); rx(1, 1, d);
        end
        6: begin
          model_fail(); poll();
          repeat (TO + 2) cyc();
        end
        7: begin
          poll(); repeat ($urandom_range(0, 5)) cyc();
          model_fail(); poll();
          repeat ($urandom_range(0, 12)) cyc();
          model_good(d); rx(1, 0, d);
        end
        8: begin
          rx(1, 0, d);
          rx(0, 1, d);
        end
        default: begin
          poll(); repeat ($urandom_range(0, 8)) cyc();
          model_good(d);
          poll_start = 1'b1; rx(1, 0, d); poll_start = 1'b0;
          d = rand_data();
          repeat ($urandom_range(0, 8)) cyc();
          model_good(d); rx(1, 0, d);
        end
      endcase
      repeat ($urandom_range(0, 3)) cyc();
    end

    repeat (5) cyc();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
